// File: rtl/dffram_arb_pkg.sv
// Shared types for the DFFRAM arbiter: controller states, port index and the
// registered response tag that travels one cycle behind each grant.
package dffram_arb_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    typedef logic port_t;

    typedef struct packed {
        logic  valid;
        port_t port;
        logic  we;
        logic  err;
    } rsp_tag_t;

    // A byte address is in range when every bit above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/dffram_rr_arb.sv
// Two-way round-robin picker. On contention the port that did not win last is
// granted; last_win only moves when a grant is actually issued.
module dffram_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_win_q;
    logic last_win_d;

    always_comb begin
        gnt        = 2'b00;
        last_win_d = last_win_q;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_win_q ? 2'b01 : 2'b10;
            end else if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
            if (|gnt) begin
                last_win_d = gnt[1];
            end
        end
    end

    // Reset to port 1 so port 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_win_q <= 1'b1;
        end else begin
            last_win_q <= last_win_d;
        end
    end

endmodule

// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM between instruction fetch (port 0) and data
// (port 1), with a sequencer that zero-fills the whole array on request.
module dffram_arbiter
    import dffram_arb_pkg::*;
#(
    parameter int unsigned AW             = 12,
    parameter int unsigned DW             = 32,
    parameter bit          CLEAR_ON_RESET = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,

    input  logic            p0_req_i,
    input  logic            p0_we_i,
    input  logic [DW/8-1:0] p0_be_i,
    input  logic [31:0]     p0_addr_i,
    input  logic [DW-1:0]   p0_wdata_i,
    output logic            p0_gnt_o,
    output logic            p0_rvalid_o,
    output logic [DW-1:0]   p0_rdata_o,
    output logic            p0_err_o,

    input  logic            p1_req_i,
    input  logic            p1_we_i,
    input  logic [DW/8-1:0] p1_be_i,
    input  logic [31:0]     p1_addr_i,
    input  logic [DW-1:0]   p1_wdata_i,
    output logic            p1_gnt_o,
    output logic            p1_rvalid_o,
    output logic [DW-1:0]   p1_rdata_o,
    output logic            p1_err_o,

    input  logic            clear_i,
    output logic            busy_o,

    output logic            ram_en_o,
    output logic [DW/8-1:0] ram_we_o,
    output logic [DW-1:0]   ram_di_o,
    output logic [AW-1:0]   ram_a_o,
    input  logic [DW-1:0]   ram_do_i
);

    localparam int unsigned BW = DW / 8;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    rsp_tag_t        rsp_q, rsp_d;

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            arb_en;

    logic            sel_we;
    logic [BW-1:0]   sel_be;
    logic [31:0]     sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_ok;
    logic            unused_addr_lsbs;

    assign req    = {p1_req_i, p0_req_i};
    assign arb_en = (state_q == IDLE);

    dffram_rr_arb u_rr_arb (
        .clk (CLK),
        .rst (RST),
        .en  (arb_en),
        .req (req),
        .gnt (gnt)
    );

    assign p0_gnt_o = gnt[0];
    assign p1_gnt_o = gnt[1];

    // Steer the granted port's request onto one set of wires.
    assign sel_we    = gnt[1] ? p1_we_i    : p0_we_i;
    assign sel_be    = gnt[1] ? p1_be_i    : p0_be_i;
    assign sel_addr  = gnt[1] ? p1_addr_i  : p0_addr_i;
    assign sel_wdata = gnt[1] ? p1_wdata_i : p0_wdata_i;
    assign sel_ok    = addr_in_range(sel_addr, AW);

    assign unused_addr_lsbs = ^sel_addr[1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rsp_d    = '0;
        ram_en_o = 1'b0;
        ram_we_o = '0;
        ram_di_o = '0;
        ram_a_o  = '0;

        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    rsp_d.valid = 1'b1;
                    rsp_d.port  = gnt[1];
                    rsp_d.we    = sel_we;
                    rsp_d.err   = ~sel_ok;
                    if (sel_ok) begin
                        ram_en_o = 1'b1;
                        ram_a_o  = sel_addr[AW+1:2];
                        ram_we_o = sel_we ? sel_be : '0;
                        ram_di_o = sel_wdata;
                    end
                end
                // A grant in this cycle still completes; the fill begins next cycle.
                if (clear_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                ram_en_o = 1'b1;
                ram_we_o = '1;
                ram_a_o  = cnt_q;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    assign busy_o = (state_q == CLEAR);

    assign p0_rvalid_o = rsp_q.valid && (rsp_q.port == 1'b0);
    assign p1_rvalid_o = rsp_q.valid && (rsp_q.port == 1'b1);
    assign p0_err_o    = p0_rvalid_o && rsp_q.err;
    assign p1_err_o    = p1_rvalid_o && rsp_q.err;

    // Read data is only meaningful for in-range reads; everything else returns zero.
    assign p0_rdata_o = (p0_rvalid_o && !rsp_q.we && !rsp_q.err) ? ram_do_i : '0;
    assign p1_rdata_o = (p1_rvalid_o && !rsp_q.we && !rsp_q.err) ? ram_do_i : '0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a behavioural DFFRAM and a response
// scoreboard checked by an independent monitor.
module tb_dffram_arbiter;

    localparam int AW = 12;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        p0_req_i, p0_we_i, p1_req_i, p1_we_i, clear_i;
    logic [3:0]  p0_be_i, p1_be_i;
    logic [31:0] p0_addr_i, p1_addr_i, p0_wdata_i, p1_wdata_i;
    logic        p0_gnt_o, p0_rvalid_o, p0_err_o, p1_gnt_o, p1_rvalid_o, p1_err_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        busy_o, ram_en_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_di_o, ram_do;
    logic [AW-1:0] ram_a_o;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    logic [31:0] mem[4096];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    dffram_arbiter dut (
        .CLK         (CLK),
        .RST         (RST),
        .p0_req_i    (p0_req_i),
        .p0_we_i     (p0_we_i),
        .p0_be_i     (p0_be_i),
        .p0_addr_i   (p0_addr_i),
        .p0_wdata_i  (p0_wdata_i),
        .p0_gnt_o    (p0_gnt_o),
        .p0_rvalid_o (p0_rvalid_o),
        .p0_rdata_o  (p0_rdata_o),
        .p0_err_o    (p0_err_o),
        .p1_req_i    (p1_req_i),
        .p1_we_i     (p1_we_i),
        .p1_be_i     (p1_be_i),
        .p1_addr_i   (p1_addr_i),
        .p1_wdata_i  (p1_wdata_i),
        .p1_gnt_o    (p1_gnt_o),
        .p1_rvalid_o (p1_rvalid_o),
        .p1_rdata_o  (p1_rdata_o),
        .p1_err_o    (p1_err_o),
        .clear_i     (clear_i),
        .busy_o      (busy_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_di_o    (ram_di_o),
        .ram_a_o     (ram_a_o),
        .ram_do_i    (ram_do)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                          input logic [3:0] we);
        logic [31:0] w = old;
        for (int b = 0; b < 4; b++) if (we[b]) w[b*8 +: 8] = di[b*8 +: 8];
        return w;
    endfunction

    // DFFRAM model: registered read, byte-masked write, Do shows the written word.
    always @(posedge CLK) begin
        if (ram_en_o) begin
            mem[ram_a_o] <= merge(mem[ram_a_o], ram_di_o, ram_we_o);
            ram_do       <= merge(mem[ram_a_o], ram_di_o, ram_we_o);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && (p0_rvalid_o || p1_rvalid_o)) begin
            if (p0_rvalid_o && p1_rvalid_o) begin
                checks++;
                errors++;
                $display("FAIL dual_rvalid: actual both ports valid required one");
            end else if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: actual p0=%0b p1=%0b required none",
                         p0_rvalid_o, p1_rvalid_o);
            end else begin
                mon_e = expq.pop_front();
                check("rsp_port", p1_rvalid_o ? 32'd1 : 32'd0, mon_e.port);
                check("rsp_cycle", cyc, mon_e.due);
                check("rsp_err", p1_rvalid_o ? p1_err_o : p0_err_o, mon_e.err);
                check("rsp_rdata", p1_rvalid_o ? p1_rdata_o : p0_rdata_o, mon_e.rdata);
            end
        end
    end

    task automatic idle();
        p0_req_i = 1'b0;
        p1_req_i = 1'b0;
        clear_i  = 1'b0;
    endtask

    // Called just after a falling edge; issues one single-port request for one cycle.
    task automatic do_req(input int p, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
        p0_req_i = (p == 0);
        p1_req_i = (p == 1);
        if (p == 0) begin
            p0_we_i = we; p0_be_i = be; p0_addr_i = addr; p0_wdata_i = wd;
        end else begin
            p1_we_i = we; p1_be_i = be; p1_addr_i = addr; p1_wdata_i = wd;
        end
        #1;
        check({name, "_gnt"}, {30'd0, p1_gnt_o, p0_gnt_o}, (p == 0) ? 32'd1 : 32'd2);
        check({name, "_en"}, ram_en_o, !exp_err);
        if (!exp_err) begin
            check({name, "_a"}, ram_a_o, addr[13:2]);
            check({name, "_we"}, ram_we_o, we ? be : 4'h0);
        end
        expq.push_back('{p, exp_err, exp_rd, cyc + 1});
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        for (int i = 0; i < 4096; i++) mem[i] = {16'hC0DE, 16'(i)};
        idle();
        p0_we_i = 0; p1_we_i = 0; p0_be_i = 0; p1_be_i = 0;
        p0_addr_i = 0; p1_addr_i = 0; p0_wdata_i = 0; p1_wdata_i = 0;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", busy_o, 0);
        check("rst_rvalid", {p1_rvalid_o, p0_rvalid_o}, 0);
        check("rst_en", ram_en_o, 0);
        check("rst_rdata", p0_rdata_o | p1_rdata_o, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Single read, then partial write followed by immediate read-back.
        do_req(0, 0, 4'h0, 32'h10, 0, 32'hC0DE0004, 0, "t1_rd");
        do_req(1, 1, 4'b0011, 32'h20, 32'hDEADBEEF, 32'h0, 0, "t2_wr");
        do_req(1, 0, 4'h0, 32'h20, 0, 32'hC0DEBEEF, 0, "t2_rd");
        idle();
        @(negedge CLK);

        // Continuous contention alternates starting with port 0.
        p0_we_i = 0; p0_addr_i = 32'h0;
        p1_we_i = 0; p1_addr_i = 32'h4;
        for (int i = 0; i < 6; i++) begin
            p0_req_i = 1'b1;
            p1_req_i = 1'b1;
            #1;
            check("t3_gnt", {30'd0, p1_gnt_o, p0_gnt_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
            expq.push_back('{i % 2, 1'b0, (i % 2 == 0) ? 32'hC0DE0000 : 32'hC0DE0001, cyc + 1});
            @(posedge CLK);
            @(negedge CLK);
        end
        idle();

        do_req(1, 0, 4'h0, 32'h0001_0000, 0, 32'h0, 1, "t4_oor");
        idle();

        // Clear requested together with a grant; p0 then waits out the fill.
        p0_req_i = 1'b1; p0_we_i = 0; p0_addr_i = 32'h10; clear_i = 1'b1;
        #1;
        check("t5_gnt_with_clear", p0_gnt_o, 1);
        expq.push_back('{0, 1'b0, 32'hC0DE0004, cyc + 1});
        @(posedge CLK);
        @(negedge CLK);
        clear_i = 1'b0; p0_addr_i = 32'h20;
        n = 0; bad = 0;
        while (busy_o && n < 5000) begin
            #1;
            if (p0_gnt_o || p1_gnt_o || !ram_en_o || ram_a_o != n[11:0] ||
                ram_we_o != 4'hF || ram_di_o != 0) bad++;
            @(posedge CLK);
            @(negedge CLK);
            n++;
        end
        check("t5_busy_cycles", n, 4096);
        check("t5_clear_bus", bad, 0);
        #1;
        check("t5_gnt_after", {30'd0, p1_gnt_o, p0_gnt_o}, 1);
        expq.push_back('{0, 1'b0, 32'h0, cyc + 1});
        @(posedge CLK);
        @(negedge CLK);
        idle();
        do_req(1, 0, 4'h0, 32'h0, 0, 32'h0, 0, "t5_rd0");
        idle();

        // Reset in the middle of a fill.
        clear_i = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        clear_i = 1'b0;
        n = 0;
        while (ram_a_o != 100 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("t6_reach_100", ram_a_o, 100);
        #2 RST = 1'b1;
        #1;
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_en", ram_en_o, 0);
        check("t6_rst_a", ram_a_o, 0);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("t6_idle_after", busy_o, 0);
        @(negedge CLK);

        // A response in flight is dropped by reset.
        p0_req_i = 1'b1; p0_we_i = 0; p0_addr_i = 32'h10;
        #1;
        check("t6_gnt_pre", p0_gnt_o, 1);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        check("t6_drop_rvalid", {p1_rvalid_o, p0_rvalid_o}, 0);
        idle();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        do_req(1, 0, 4'h0, 32'h10, 0, 32'h0, 0, "t6_post");
        idle();

        repeat (3) @(negedge CLK);
        check("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
